// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - Round-robin arbiter sharing one memory port between fetch (I) and load/store (D)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_req, i_addr                 fetch request (held until i_done)
//   i_done, i_rdata, i_err        fetch completion pulse, data, timeout flag
//   d_req, d_we, d_addr,
//   d_wdata, d_be                 load/store request (held until d_done)
//   d_done, d_rdata, d_err        load/store completion pulse, data (0 for stores), timeout flag
//   m_req, m_we, m_addr,
//   m_wdata, m_be                 registered memory request
//   m_ack, m_rdata                memory completion and read data (same cycle)
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a memory transaction
// after TIMEOUT cycles without m_ack (completes with x_err=1, x_rdata=0).
// Without it the arbiter waits indefinitely and i_err/d_err are tied to 0.

module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic        m_ack,
    input  logic [31:0] m_rdata
);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT must be within 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEM_I = 2'd1,
        MEM_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        last_d_q, last_d_d;    // 1: most recent grant went to D
    logic        m_req_q, m_req_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [3:0]  m_be_q, m_be_d;
    logic        i_done_q, i_done_d;
    logic        d_done_q, d_done_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        grant_d;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO = 16'(TIMEOUT);
    logic [15:0] cnt_q, cnt_d;
    logic        i_err_q, i_err_d;
    logic        d_err_q, d_err_d;
`endif

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_be_d    = m_be_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        grant_d   = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        i_err_d   = i_err_q;
        d_err_d   = d_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    // D takes the port when alone, or on a tie when I was served last
                    grant_d  = d_req && (!i_req || !last_d_q);
                    last_d_d = grant_d;
                    m_req_d  = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d    = 16'd0;
`endif
                    if (grant_d) begin
                        m_we_d    = d_we;
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                        m_be_d    = d_be;
                        state_d   = MEM_D;
                    end else begin
                        m_we_d    = 1'b0;
                        m_addr_d  = i_addr;
                        m_wdata_d = 32'd0;
                        m_be_d    = 4'hF;
                        state_d   = MEM_I;
                    end
                end
            end
            MEM_I, MEM_D: begin
                if (m_ack) begin
                    m_req_d = 1'b0;
                    state_d = RESP;
                    if (state_q == MEM_I) begin
                        i_done_d  = 1'b1;
                        i_rdata_d = m_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
                        i_err_d   = 1'b0;
`endif
                    end else begin
                        d_done_d  = 1'b1;
                        d_rdata_d = m_we_q ? 32'd0 : m_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
                        d_err_d   = 1'b0;
`endif
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                // An ack in the same cycle as expiry is handled above and wins
                else if (cnt_q + 16'd1 == TMO) begin
                    m_req_d = 1'b0;
                    state_d = RESP;
                    if (state_q == MEM_I) begin
                        i_done_d  = 1'b1;
                        i_rdata_d = 32'd0;
                        i_err_d   = 1'b1;
                    end else begin
                        d_done_d  = 1'b1;
                        d_rdata_d = 32'd0;
                        d_err_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            RESP: begin
                // Requests are not sampled here so a dropping requester is never re-granted
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= 32'd0;
            m_wdata_q <= 32'd0;
            m_be_q    <= 4'd0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q     <= 16'd0;
            i_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_be_q    <= m_be_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            i_err_q   <= i_err_d;
            d_err_q   <= d_err_d;
`endif
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_be    = m_be_q;
    assign i_done  = i_done_q;
    assign d_done  = d_done_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign i_err   = i_err_q;
    assign d_err   = d_err_q;
`else
    assign i_err   = 1'b0;
    assign d_err   = 1'b0;
`endif

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares a single memory port between the CPU's instruction-fetch requester (I) and its load/store requester (D). Accepts one outstanding transaction at a time using a req/done handshake on each side and a req/ack handshake toward memory. Resolves simultaneous requests round-robin. Sits between the fetch/load-store stages of the multi-cycle core and the memory model.

## Interface
Parameters:
- TIMEOUT, 255: cycles to wait for m_ack before aborting, legal range 1..65535. Used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset. Synchronous, active-high, sampled on posedge clk.
- i_req  in  1  fetch request. Held with i_addr stable until i_done.
- i_addr  in  32  fetch address.
- i_done  out  1  one-cycle pulse: fetch finished.
- i_rdata  out  32  fetch data, valid while i_done=1.
- i_err  out  1  fetch timed out, valid while i_done=1.
- d_req  in  1  load/store request. Held with all d_* inputs stable until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_be  in  4  byte enables.
- d_done  out  1  one-cycle pulse: load/store finished.
- d_rdata  out  32  load data, valid while d_done=1. 0 for stores.
- d_err  out  1  load/store timed out, valid while d_done=1.
- m_req  out  1  memory request, registered.
- m_we  out  1  memory write enable.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_be  out  4  memory byte enables. 4'b1111 for fetches.
- m_ack  in  1  memory completion. m_rdata is valid in the same cycle.
- m_rdata  in  32  memory read data.

## Operation
- States:
  - IDLE: no transaction.
  - MEM_I: fetch in progress on the memory port.
  - MEM_D: load/store in progress on the memory port.
  - RESP: done pulse cycle. Lasts exactly one cycle.
- IDLE:
  - If only i_req: latch the I request into the m_* registers, set m_req=1, go to MEM_I.
  - If only d_req: latch the D request into the m_* registers, set m_req=1, go to MEM_D.
  - If both: grant the requester not granted last. Last-grant flag resets to I, so D wins the first tie.
- MEM_x:
  - Hold m_* stable while m_ack=0.
  - On m_ack=1: clear m_req, capture m_rdata (forced to 0 for stores), set the owner's x_done=1, go to RESP.
- RESP:
  - x_done and x_rdata are valid this cycle. x_done clears on the next edge; state returns to IDLE.
  - No request is sampled in RESP, so a requester dropping req this cycle is never granted twice.
- The other requester's req is ignored while a transaction is in flight; it is served from IDLE afterwards.
- Reset:
  - All outputs are 0: m_req, m_we, m_addr, m_wdata, m_be, i_done, d_done, i_rdata, d_rdata, i_err, d_err.
  - State returns to IDLE; last-grant flag returns to I.
- Reset mid-transaction: the transaction is abandoned, no done pulse is produced, and m_req=0 from the cycle after rst is sampled.

## Timing
- Request seen in IDLE at cycle 0 -> m_req=1 in cycle 1.
- m_ack in cycle k (k≥1) -> x_done=1 in cycle k+1 -> IDLE in cycle k+2.
- Earliest next m_req is cycle k+3. Zero-wait-state throughput is one transaction per 3 cycles.
- m_ack while m_req=0 is ignored.
- x_done never asserts for both requesters in the same cycle.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to MEM_x and increments each MEM_x cycle without m_ack.
  - When the counter reaches TIMEOUT, go to RESP with x_err=1 and x_rdata=0, and drop m_req.
  - m_ack arriving in the same cycle the counter reaches TIMEOUT wins: completion is normal, err=0.
- Not defined:
  - MEM_x waits indefinitely. i_err and d_err are tied to 0. No counter is present.

## Test plan
- Fetch only, i_addr=0x100, m_ack one cycle after m_req with m_rdata=0x00000033 -> m_addr=0x100, m_be=4'hF; i_done=1 for one cycle with i_rdata=0x33; d_done stays 0.
- Store, d_addr=0x20, d_wdata=0xDEADBEEF, d_be=4'h3, m_ack after 4 wait cycles -> m_we=1 and m_* stable for 5 cycles; d_done=1 with d_rdata=0.
- i_req and d_req raised together and held after each done, three rounds -> grant order D, I, D; each done is a single pulse; no double grant.
- rst asserted while in MEM_D with m_req=1 -> next cycle m_req=0, all outputs 0; no d_done is ever produced; a subsequent tie is granted to D.
- MEM_ARB_TIMEOUT_EN defined, TIMEOUT=8, m_ack never asserted -> i_done=1 with i_err=1 and i_rdata=0 after 8 MEM_I cycles. Without the macro, m_req is still 1 after 100 cycles.
